// File: rtl/housekeeping_spi_wide.sv
// Housekeeping SPI slave: 8-bit command, ADDR_WIDTH address, DATA_WIDTH words, flash pass-through.
// Define HKSPI_NOINC_EN so that command bit 1 holds the address across words (FIFO-port bursts).
`timescale 1ns/1ps
module housekeeping_spi_wide #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  SCK,
    input  logic                  csb_reset,
    input  logic                  SDI,
    output logic                  SDO,
    output logic                  sdoena,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic [DATA_WIDTH-1:0] odata,
    output logic [ADDR_WIDTH-1:0] oaddr,
    output logic                  rdstb,
    output logic                  wrstb,
    output logic                  pass_thru,
    output logic                  pass_thru_delay,
    output logic                  pass_thru_reset
);
    localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_LEN = (MAX_AD > 8) ? MAX_AD : 8;
    localparam int CNT_W   = $clog2(MAX_LEN);
    localparam int PW      = DATA_WIDTH - 1;

    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_COMMAND  = 2'd0,
        ST_ADDRESS  = 2'd1,
        ST_DATA     = 2'd2,
        ST_PASSTHRU = 2'd3
    } state_t;

    // Rising-edge state
    state_t                  state_q,   state_d;
    logic [CNT_W-1:0]        count_q,   count_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [PW-1:0]           predata_q, predata_d;
    logic                    wr_q,      wr_d;
    logic                    rd_q,      rd_d;
    logic [2:0]              nnn_q,     nnn_d;
    logic                    noinc_q,   noinc_d;
    logic                    pre_pt_q,  pre_pt_d;
    logic                    ptd_q,     ptd_d;
    logic                    pt_q,      pt_d;
    logic                    rdstb_q,   rdstb_d;

    // Falling-edge state
    logic [DATA_WIDTH-1:0]   ldata_q,   ldata_d;
    logic                    sdoena_q,  sdoena_d;
    logic                    wrstb_q,   wrstb_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            state_q   <= ST_COMMAND;
            count_q   <= '0;
            addr_q    <= '0;
            predata_q <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            nnn_q     <= '0;
            noinc_q   <= 1'b0;
            pre_pt_q  <= 1'b0;
            ptd_q     <= 1'b0;
            pt_q      <= 1'b0;
            rdstb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            predata_q <= predata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            nnn_q     <= nnn_d;
            noinc_q   <= noinc_d;
            pre_pt_q  <= pre_pt_d;
            ptd_q     <= ptd_d;
            pt_q      <= pt_d;
            rdstb_q   <= rdstb_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q + 1'b1;
        addr_d    = addr_q;
        predata_d = predata_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        nnn_d     = nnn_q;
        noinc_d   = noinc_q;
        pre_pt_d  = pre_pt_q;
        ptd_d     = ptd_q;
        pt_d      = pt_q;
        rdstb_d   = 1'b0;
        case (state_q)
            ST_COMMAND: begin
                if (count_q == CNT_W'(0)) begin
                    wr_d = SDI;
                end else if (count_q == CNT_W'(1)) begin
                    rd_d = SDI;
                end else if (count_q < CNT_W'(5)) begin
                    nnn_d = {nnn_q[1:0], SDI};
                end else if (count_q == CNT_W'(5)) begin
                    pre_pt_d = SDI;
                end else if (count_q == CNT_W'(6)) begin
                    ptd_d = pre_pt_q;
`ifdef HKSPI_NOINC_EN
                    noinc_d = SDI;
`endif
                end else begin
                    pre_pt_d = 1'b0;
                    count_d  = '0;
                    state_d  = ptd_q ? ST_PASSTHRU : ST_ADDRESS;
                end
            end
            ST_ADDRESS: begin
                addr_d = ADDR_WIDTH'({addr_q, SDI});
                if (count_q == CNT_ADDR_LAST) begin
                    rdstb_d = rd_q;
                    count_d = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                predata_d = PW'({predata_q, SDI});
                if (count_q == CNT_DATA_LAST) begin
                    rdstb_d = rd_q;
                    count_d = '0;
                    // nnn==1 is the last counted word; nnn==0 streams forever
                    if (nnn_q == 3'd1) begin
                        state_d = ST_COMMAND;
                    end else begin
                        if (nnn_q != 3'd0) nnn_d = nnn_q - 3'd1;
                        if (!noinc_q) addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_PASSTHRU: begin
                pt_d    = 1'b1;
                count_d = count_q;
            end
            default: state_d = ST_COMMAND;
        endcase
    end

    // Falling edge launches SDO and the write strobe, half a cycle ahead of the sampling edge
    always_comb begin
        ldata_d  = ldata_q;
        sdoena_d = 1'b0;
        wrstb_d  = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (rd_q) begin
                    sdoena_d = 1'b1;
                    ldata_d  = (count_q == '0) ? idata : (ldata_q << 1);
                end
                wrstb_d = wr_q && (count_q == CNT_DATA_LAST);
            end
            ST_PASSTHRU: sdoena_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(negedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            ldata_q  <= '0;
            sdoena_q <= 1'b0;
            wrstb_q  <= 1'b0;
        end else begin
            ldata_q  <= ldata_d;
            sdoena_q <= sdoena_d;
            wrstb_q  <= wrstb_d;
        end
    end

    always_comb begin
        oaddr           = (state_q == ST_ADDRESS) ? ADDR_WIDTH'({addr_q, SDI}) : addr_q;
        odata           = {predata_q, SDI};
        SDO             = ldata_q[DATA_WIDTH-1];
        sdoena          = sdoena_q;
        rdstb           = rdstb_q;
        wrstb           = wrstb_q;
        pass_thru       = pt_q;
        pass_thru_delay = ptd_q;
        pass_thru_reset = ptd_q | pre_pt_q;
    end

endmodule

// File: tb/tb_housekeeping_spi_wide.sv
// Bench for housekeeping_spi_wide: default 8/8 instance plus a 16/32 instance sharing the SPI bus.
`timescale 1ns/1ps
module tb_housekeeping_spi_wide;

    logic sck, sdi, csb_reset;

    logic       d_sdo, d_sdoena, d_rdstb, d_wrstb, d_pt, d_ptd, d_ptr;
    logic [7:0] d_idata, d_odata, d_oaddr;
    logic [7:0] d_mem [256];

    logic        w_sdo, w_sdoena, w_rdstb, w_wrstb, w_pt, w_ptd, w_ptr;
    logic [31:0] w_idata, w_odata;
    logic [15:0] w_oaddr;

    housekeeping_spi_wide dut_d (
        .SCK(sck), .csb_reset(csb_reset), .SDI(sdi), .SDO(d_sdo), .sdoena(d_sdoena),
        .idata(d_idata), .odata(d_odata), .oaddr(d_oaddr), .rdstb(d_rdstb), .wrstb(d_wrstb),
        .pass_thru(d_pt), .pass_thru_delay(d_ptd), .pass_thru_reset(d_ptr)
    );

    housekeeping_spi_wide #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut_w (
        .SCK(sck), .csb_reset(csb_reset), .SDI(sdi), .SDO(w_sdo), .sdoena(w_sdoena),
        .idata(w_idata), .odata(w_odata), .oaddr(w_oaddr), .rdstb(w_rdstb), .wrstb(w_wrstb),
        .pass_thru(w_pt), .pass_thru_delay(w_ptd), .pass_thru_reset(w_ptr)
    );

    // Register-file models answering reads combinationally
    assign d_idata = d_mem[d_oaddr];
    assign w_idata = (w_oaddr == 16'h1234) ? 32'hDEAD_BEEF : 32'h0000_0000;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_rd[$];
    int   checks;
    int   errors;
    int   bitn;
    logic sel_wide;
    event pre_ev, post_ev;

    // Write scoreboard: sampled just before the rising edge the register file writes on
    always @(pre_ev) begin
        logic        m_wr;
        logic [15:0] m_a;
        logic [31:0] m_d;
        wr_t         e;
        m_wr = sel_wide ? w_wrstb : d_wrstb;
        m_a  = sel_wide ? w_oaddr : {8'h00, d_oaddr};
        m_d  = sel_wide ? w_odata : {24'h0, d_odata};
        if (m_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: bit %0d got addr=%h data=%h, no write expected", bitn + 1, m_a, m_d);
            end else begin
                e = exp_wr.pop_front();
                if (m_a !== e.a || m_d !== e.d) begin
                    errors++;
                    $display("FAIL wr_value: bit %0d got addr=%h data=%h expected addr=%h data=%h",
                             bitn + 1, m_a, m_d, e.a, e.d);
                end
            end
        end
    end

    // Read-strobe scoreboard: sampled 1 ns after the rising edge that set it
    always @(post_ev) begin
        logic m_rd;
        int   e;
        m_rd = sel_wide ? w_rdstb : d_rdstb;
        if (m_rd) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rdstb at bit %0d, none expected", bitn);
            end else begin
                e = exp_rd.pop_front();
                if (bitn != e) begin
                    errors++;
                    $display("FAIL rd_position: rdstb at bit %0d expected bit %0d", bitn, e);
                end
            end
        end
    end

    task automatic spi_bit(input logic b, output logic so, output logic oe);
        sdi = b;
        #4;
        so = sel_wide ? w_sdo : d_sdo;
        oe = sel_wide ? w_sdoena : d_sdoena;
        -> pre_ev;
        #1;
        sck = 1'b1;
        bitn++;
        #1;
        -> post_ev;
        #4;
        sck = 1'b0;
    endtask

    task automatic spi_word(input logic [31:0] w, input int n, output logic [31:0] rx, output int oe_cnt);
        logic so, oe;
        rx     = '0;
        oe_cnt = 0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(w[i], so, oe);
            rx = {rx[30:0], so};
            if (oe === 1'b1) oe_cnt++;
        end
    endtask

    task automatic do_reset();
        csb_reset = 1'b1;
        #5;
        csb_reset = 1'b0;
        #5;
        bitn = 0;
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d writes / %0d rdstb still pending, expected 0 / 0",
                     name, exp_wr.size(), exp_rd.size());
        end
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        logic [6:0] dflags, wflags;
        #2;
        dflags = {d_sdo, d_sdoena, d_rdstb, d_wrstb, d_pt, d_ptd, d_ptr};
        wflags = {w_sdo, w_sdoena, w_rdstb, w_wrstb, w_pt, w_ptd, w_ptr};
        checks++;
        if (dflags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags_d: got %b expected 0000000", dflags);
        end
        checks++;
        if (wflags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags_w: got %b expected 0000000", wflags);
        end
        checks++;
        if (d_oaddr !== 8'h00 || w_oaddr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_addr: got %h/%h expected 00/0000", d_oaddr, w_oaddr);
        end
        csb_reset = 1'b0;
        #5;
    endtask

    task automatic test_write();
        logic [31:0] rx;
        int          oe, oe_total;
        do_reset();
        sel_wide = 1'b0;
        exp_wr.push_back('{a: 16'h0010, d: 32'h0000_00A5});
        spi_word(32'h80, 8, rx, oe);  oe_total = oe;
        spi_word(32'h10, 8, rx, oe);  oe_total += oe;
        spi_word(32'hA5, 8, rx, oe);  oe_total += oe;
        checks++;
        if (oe_total != 0) begin
            errors++;
            $display("FAIL write_sdoena: got %0d enabled bits expected 0", oe_total);
        end
        check_queues("write");
    endtask

    task automatic test_read_stream();
        logic [31:0] rx;
        logic [7:0]  exp_sdo[$];
        logic [7:0]  e;
        int          oe;
        do_reset();
        sel_wide  = 1'b0;
        d_mem[4]  = 8'h3C;
        d_mem[5]  = 8'hC3;
        d_mem[6]  = 8'h5A;
        exp_rd.push_back(16);
        exp_rd.push_back(24);
        exp_rd.push_back(32);
        spi_word(32'h40, 8, rx, oe);
        spi_word(32'h04, 8, rx, oe);
        checks++;
        if (oe != 0) begin
            errors++;
            $display("FAIL read_sdoena_early: got %0d enabled address bits expected 0", oe);
        end
        exp_sdo.push_back(8'h3C);
        exp_sdo.push_back(8'hC3);
        for (int w = 0; w < 2; w++) begin
            spi_word(32'h00, 8, rx, oe);
            e = exp_sdo.pop_front();
            checks++;
            if (rx[7:0] !== e || oe != 8) begin
                errors++;
                $display("FAIL read_word%0d: got sdo=%h oe_bits=%0d expected sdo=%h oe_bits=8", w, rx[7:0], oe, e);
            end
        end
        check_queues("read");
    endtask

    task automatic test_wrap();
        logic [31:0] rx;
        int          oe;
        do_reset();
        sel_wide = 1'b0;
        exp_wr.push_back('{a: 16'h00FF, d: 32'h11});
        exp_wr.push_back('{a: 16'h0000, d: 32'h22});
        spi_word(32'h90, 8, rx, oe);
        spi_word(32'hFF, 8, rx, oe);
        spi_word(32'h11, 8, rx, oe);
        spi_word(32'h22, 8, rx, oe);
        // Back in COMMAND the address output ignores SDI
        sdi = 1'b1;
        #1;
        checks++;
        if (d_oaddr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_cmd_addr: got %h expected 00", d_oaddr);
        end
        spi_word(32'h00, 8, rx, oe);
        // Now in ADDRESS: retained addr 00 shifts in SDI
        sdi = 1'b1;
        #1;
        checks++;
        if (d_oaddr !== 8'h01) begin
            errors++;
            $display("FAIL wrap_next_cmd: got oaddr=%h expected 01", d_oaddr);
        end
        check_queues("wrap");
    endtask

    task automatic test_wide();
        logic [31:0] rx;
        int          oe;
        do_reset();
        sel_wide = 1'b1;
        exp_wr.push_back('{a: 16'h1234, d: 32'h0102_0304});
        exp_rd.push_back(24);
        exp_rd.push_back(56);
        spi_word(32'hC8, 8, rx, oe);
        spi_word(32'h1234, 16, rx, oe);
        spi_word(32'h0102_0304, 32, rx, oe);
        checks++;
        if (rx !== 32'hDEAD_BEEF || oe != 32) begin
            errors++;
            $display("FAIL wide_sdo: got %h oe_bits=%0d expected deadbeef oe_bits=32", rx, oe);
        end
        // A pass-through command parses only if the FSM returned to COMMAND
        spi_word(32'h04, 8, rx, oe);
        checks++;
        if (w_ptd !== 1'b1 || w_pt !== 1'b0 || w_oaddr !== 16'h1234) begin
            errors++;
            $display("FAIL wide_return_cmd: got ptd=%b pt=%b oaddr=%h expected ptd=1 pt=0 oaddr=1234",
                     w_ptd, w_pt, w_oaddr);
        end
        check_queues("wide");
    endtask

    task automatic test_passthru();
        logic [7:0] cmd;
        logic       so, oe;
        logic [6:0] flags;
        do_reset();
        sel_wide = 1'b0;
        cmd = 8'hC4;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], so, oe);
            if (bitn == 6) begin
                checks++;
                if (d_ptd !== 1'b0 || d_ptr !== 1'b1) begin
                    errors++;
                    $display("FAIL pt_bit6: got ptd=%b ptr=%b expected ptd=0 ptr=1", d_ptd, d_ptr);
                end
            end else if (bitn == 7) begin
                checks++;
                if (d_ptd !== 1'b1) begin
                    errors++;
                    $display("FAIL pt_bit7: got ptd=%b expected 1", d_ptd);
                end
            end
        end
        checks++;
        if (d_pt !== 1'b0) begin
            errors++;
            $display("FAIL pt_bit8: got pass_thru=%b expected 0", d_pt);
        end
        spi_bit(1'b0, so, oe);
        checks++;
        if (oe !== 1'b1 || d_pt !== 1'b1 || d_ptr !== 1'b1) begin
            errors++;
            $display("FAIL pt_active: got sdoena=%b pt=%b ptr=%b expected 1 1 1", oe, d_pt, d_ptr);
        end
        csb_reset = 1'b1;
        #1;
        flags = {d_sdo, d_sdoena, d_rdstb, d_wrstb, d_pt, d_ptd, d_ptr};
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL pt_async_reset: got %b expected 0000000", flags);
        end
        #4;
        csb_reset = 1'b0;
        check_queues("passthru");
    endtask

    task automatic test_noinc();
        logic [31:0] rx;
        int          oe;
        do_reset();
        sel_wide = 1'b0;
`ifdef HKSPI_NOINC_EN
        exp_wr.push_back('{a: 16'h0020, d: 32'h11});
        exp_wr.push_back('{a: 16'h0020, d: 32'h22});
        exp_wr.push_back('{a: 16'h0020, d: 32'h33});
`else
        exp_wr.push_back('{a: 16'h0020, d: 32'h11});
        exp_wr.push_back('{a: 16'h0021, d: 32'h22});
        exp_wr.push_back('{a: 16'h0022, d: 32'h33});
`endif
        spi_word(32'h82, 8, rx, oe);
        spi_word(32'h20, 8, rx, oe);
        spi_word(32'h11, 8, rx, oe);
        spi_word(32'h22, 8, rx, oe);
        spi_word(32'h33, 8, rx, oe);
        check_queues("noinc");
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        int          oe;
        do_reset();
        sel_wide = 1'b0;
        spi_word(32'h80, 8, rx, oe);
        spi_word(32'h10, 8, rx, oe);
        spi_word(32'h1F, 5, rx, oe);
        csb_reset = 1'b1;
        #1;
        checks++;
        if (d_wrstb !== 1'b0 || d_oaddr !== 8'h00) begin
            errors++;
            $display("FAIL abort_state: got wrstb=%b oaddr=%h expected 0 / 00", d_wrstb, d_oaddr);
        end
        #4;
        csb_reset = 1'b0;
        #5;
        bitn = 0;
        exp_wr.push_back('{a: 16'h0030, d: 32'h77});
        spi_word(32'h80, 8, rx, oe);
        spi_word(32'h30, 8, rx, oe);
        spi_word(32'h77, 8, rx, oe);
        check_queues("abort");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        sck       = 1'b0;
        sdi       = 1'b0;
        csb_reset = 1'b1;
        sel_wide  = 1'b0;
        checks    = 0;
        errors    = 0;
        bitn      = 0;
        for (int i = 0; i < 256; i++) d_mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read_stream();
        test_wrap();
        test_wide();
        test_passthru();
        test_noinc();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
